add_mlt_ctrl: RTL and testbench

//  Moore FSM that sequences the repeated-addition multiplier datapath (regs A/P/B, zero comparator, adder).
//  On start: loads A and B, clears P, then repeats P<=A+P / B<=B-1 until the comparator reports B==0.

---
 rtl/add_mlt_ctrl.sv | 112 +++++++++++
 tb/tb_add_mlt_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/add_mlt_ctrl.sv
// Moore controller for the repeated-addition multiplier: loads A/B, clears P,
// then adds A into P and decrements B until the zero comparator reports B==0.
module add_mlt_ctrl #(
    parameter int SETTLE = 2,
    parameter int CW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          eqz,
    output logic          ld_a,
    output logic          ld_b,
    output logic          cr_p,
    output logic          ld_p,
    output logic          dc_b,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] iter_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_ADD   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    // WAIT lasts exactly SETTLE cycles, so the counter starts at SETTLE-1.
    localparam logic [3:0] WAIT_INIT = 4'(SETTLE - 1);

    logic [2:0] state;
    logic [3:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            iter_cnt <= '0;
        end else if (state != S_IDLE && abort) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_LOAD;
                        iter_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    state    <= S_WAIT;
                    wait_cnt <= WAIT_INIT;
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= S_CHECK;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_CHECK: begin
                    state <= eqz ? S_DONE : S_ADD;
                end
                S_ADD: begin
                    state    <= S_WAIT;
                    wait_cnt <= WAIT_INIT;
                    iter_cnt <= iter_cnt + 1'b1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        ld_a = 1'b0;
        ld_b = 1'b0;
        cr_p = 1'b0;
        ld_p = 1'b0;
        dc_b = 1'b0;
        done = 1'b0;
        busy = (state != S_IDLE);
        case (state)
            S_LOAD: begin
                ld_a = 1'b1;
                ld_b = 1'b1;
                cr_p = 1'b1;
            end
            S_ADD: begin
                ld_p = 1'b1;
                dc_b = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Load strobes and update strobes must never overlap on the datapath.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!((ld_a || ld_b || cr_p) && (ld_p || dc_b)));
        end
    end

endmodule

// File: tb/tb_add_mlt_ctrl.sv
// Scoreboard bench for add_mlt_ctrl: two controllers (SETTLE=2/CW=16 and
// SETTLE=1/CW=4) each drive a behavioural A/P/B datapath with a clocked comparator.
module tb_add_mlt_ctrl;

    localparam int S0 = 2;
    localparam int S1 = 1;

    typedef struct {
        int          start_cyc;
        int          done_off;
        logic [31:0] product;
        logic [31:0] iters;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   ldp_idx = 0;

    exp_t sb0[$];
    exp_t sb1[$];

    logic        start0 = 1'b0, abort0 = 1'b0, eqz0 = 1'b0;
    logic        ld_a0, ld_b0, cr_p0, ld_p0, dc_b0, busy0, done0;
    logic [15:0] iter_cnt0;
    logic [15:0] dataa0 = '0, datab0 = '0, a0 = '0, b0 = '0, p0 = '0;

    logic        start1 = 1'b0, abort1 = 1'b0, eqz1 = 1'b0;
    logic        ld_a1, ld_b1, cr_p1, ld_p1, dc_b1, busy1, done1;
    logic [3:0]  iter_cnt1;
    logic [15:0] dataa1 = '0, datab1 = '0, a1 = '0, b1 = '0, p1 = '0;

    add_mlt_ctrl #(.SETTLE(S0), .CW(16)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0), .eqz(eqz0),
        .ld_a(ld_a0), .ld_b(ld_b0), .cr_p(cr_p0), .ld_p(ld_p0), .dc_b(dc_b0),
        .busy(busy0), .done(done0), .iter_cnt(iter_cnt0)
    );

    add_mlt_ctrl #(.SETTLE(S1), .CW(4)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .eqz(eqz1),
        .ld_a(ld_a1), .ld_b(ld_b1), .cr_p(cr_p1), .ld_p(ld_p1), .dc_b(dc_b1),
        .busy(busy1), .done(done1), .iter_cnt(iter_cnt1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural datapaths; eqz is registered to model a clocked comparator.
    always @(posedge clk) begin
        if (ld_a0) a0 <= dataa0;
        if (ld_b0) b0 <= datab0;
        else if (dc_b0) b0 <= b0 - 16'd1;
        if (cr_p0) p0 <= '0;
        else if (ld_p0) p0 <= p0 + a0;
        eqz0 <= (b0 == 16'd0);
        if (ld_a1) a1 <= dataa1;
        if (ld_b1) b1 <= datab1;
        else if (dc_b1) b1 <= b1 - 16'd1;
        if (cr_p1) p1 <= '0;
        else if (ld_p1) p1 <= p1 + a1;
        eqz1 <= (b1 == 16'd0);
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        dataa0 = a;
        datab0 = b;
        start0 = 1'b1;
        e.start_cyc = cyc;
        e.done_off  = 3 + S0 + int'(b) * (S0 + 2);
        e.product   = 32'((a * b) & 16'hFFFF);
        e.iters     = 32'(b);
        sb0.push_back(e);
        tick(1);
        start0 = 1'b0;
    endtask

    task automatic waitIdle(input int limit);
        int n = 0;
        while ((sb0.size() != 0 || sb1.size() != 0) && n < limit) begin
            tick(1);
            n++;
        end
        checkOutput("drain", 32'(sb0.size() + sb1.size()), 0);
        sb0.delete();
        sb1.delete();
        ldp_idx = 0;
        tick(2);
    endtask

    // Checks every ADD pulse position and every done pulse against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (ld_p0) begin
                if (sb0.size() != 0) begin
                    checkOutput("ldp_cycle", 32'(cyc - sb0[0].start_cyc), 32'(3 + S0 + ldp_idx * (S0 + 2)));
                    ldp_idx++;
                end else begin
                    checkOutput("ldp_no_op", 1, 0);
                end
                checkOutput("ldp_dcb", 32'(dc_b0), 1);
            end
            if ((ld_a0 || ld_b0 || cr_p0) && (ld_p0 || dc_b0)) checkOutput("strobe_excl", 1, 0);
            if (done0) begin
                if (sb0.size() == 0) begin
                    checkOutput("unexp_done0", 1, 0);
                end else begin
                    e = sb0.pop_front();
                    checkOutput("done_cycle0", 32'(cyc - e.start_cyc), 32'(e.done_off));
                    checkOutput("product0", 32'(p0), e.product);
                    checkOutput("iters0", 32'(iter_cnt0), e.iters);
                    checkOutput("busy_done0", 32'(busy0), 1);
                    ldp_idx = 0;
                end
            end
            if (done1) begin
                if (sb1.size() == 0) begin
                    checkOutput("unexp_done1", 1, 0);
                end else begin
                    e = sb1.pop_front();
                    checkOutput("done_cycle1", 32'(cyc - e.start_cyc), 32'(e.done_off));
                    checkOutput("product1", 32'(p1), e.product);
                    checkOutput("iters1", 32'(iter_cnt1), e.iters);
                end
            end
        end
    end

    initial begin
        exp_t e;
        int   s;

        tick(3);
        checkOutput("rst_busy", 32'(busy0), 0);
        checkOutput("rst_done", 32'(done0), 0);
        checkOutput("rst_strobes", 32'({ld_a0, ld_b0, cr_p0, ld_p0, dc_b0}), 0);
        checkOutput("rst_iter", 32'(iter_cnt0), 0);
        checkOutput("rst_busy1", 32'(busy1), 0);
        rst = 1'b0;
        tick(2);

        // Basic products including the B==0 boundary.
        applyStimulus(16'd3, 16'd4);
        waitIdle(200);
        applyStimulus(16'd7, 16'd0);
        waitIdle(200);
        applyStimulus(16'd11, 16'd6);
        waitIdle(200);

        // Abort in WAIT after two additions, then a fresh run.
        s = cyc;
        applyStimulus(16'd5, 16'd3);
        tick(9);
        abort0 = 1'b1;
        tick(1);
        abort0 = 1'b0;
        checkOutput("abort_cycle", 32'(cyc - s), 11);
        checkOutput("abort_busy", 32'(busy0), 0);
        checkOutput("abort_iter", 32'(iter_cnt0), 2);
        checkOutput("abort_ldp_count", 32'(ldp_idx), 2);
        sb0.delete();
        ldp_idx = 0;
        tick(30);
        applyStimulus(16'd2, 16'd2);
        waitIdle(200);

        // Synchronous reset mid-run while start is held high.
        applyStimulus(16'd9, 16'd9);
        start0 = 1'b1;
        tick(6);
        checkOutput("held_busy", 32'(busy0), 1);
        checkOutput("held_iter", 32'(iter_cnt0), 1);
        rst = 1'b1;
        start0 = 1'b0;
        tick(1);
        rst = 1'b0;
        checkOutput("midrst_busy", 32'(busy0), 0);
        checkOutput("midrst_strobes", 32'({ld_a0, ld_b0, cr_p0, ld_p0, dc_b0, done0}), 0);
        checkOutput("midrst_iter", 32'(iter_cnt0), 0);
        sb0.delete();
        ldp_idx = 0;
        tick(50);

        // Start held high: DONE, one IDLE cycle, then a new LOAD.
        dataa0 = 16'd4;
        datab0 = 16'd1;
        start0 = 1'b1;
        s = cyc;
        e.start_cyc = s;      e.done_off = 9; e.product = 4; e.iters = 1;
        sb0.push_back(e);
        e.start_cyc = s + 10;
        sb0.push_back(e);
        tick(10);
        checkOutput("b2b_idle_busy", 32'(busy0), 0);
        checkOutput("b2b_hold_iter", 32'(iter_cnt0), 1);
        tick(1);
        checkOutput("b2b_load", 32'(ld_a0), 1);
        checkOutput("b2b_iter_clr", 32'(iter_cnt0), 0);
        start0 = 1'b0;
        waitIdle(200);

        // SETTLE=1 controller with 4-bit iter_cnt that wraps.
        dataa1 = 16'd1;
        datab1 = 16'd20;
        start1 = 1'b1;
        e.start_cyc = cyc;
        e.done_off  = 4 + 3 * 20;
        e.product   = 20;
        e.iters     = 20 % 16;
        sb1.push_back(e);
        tick(1);
        start1 = 1'b0;
        waitIdle(300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
